imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction-memory interface that the IF stage reads.
- Accepts a byte-serial program stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word into instruction memory at consecutive word addresses.
- Holds the core off (core_hold) until the whole image is written.

Parameters:
- ADDR_W, 32, width of wr_addr (byte address)
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be 4-aligned
- LEN_W, 16, width of load_len (word count)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins a load of load_len words
- load_len  input  LEN_W  number of 32-bit words to load; sampled on start
- in_valid  input  1  stream byte valid
- in_data  input  8  stream byte
- in_ready  output  1  loader can accept a byte this cycle
- wr_en  output  1  instruction-memory write strobe, one cycle per word
- wr_addr  output  ADDR_W  byte address of the word being written
- wr_data  output  32  assembled word
- core_hold  output  1  high while loading; keeps IF/PC held
- done  output  1  load complete; stays high until next start

Behaviour:
- Clock is clk; reset is asynchronous, active-low, on rst_n.
- Reset values: in_ready=0, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, core_hold=1, done=0. FSM goes to IDLE; byte index, word counter and partial word are cleared.
- FSM states:
  - IDLE: core_hold=1, in_ready=0. On start: latch load_len and set wr_addr=BASE_ADDR. If load_len==0 go to DONE, otherwise go to RECV.
  - RECV: in_ready=1. A byte transfers when in_valid & in_ready. Byte k (0..3) lands in word bits [8k+7:8k]. After the 4th byte, go to WRITE.
  - WRITE (one cycle): wr_en=1, wr_data=assembled word, wr_addr=current address, in_ready=0. Next cycle: wr_addr += 4 (wraps mod 2^ADDR_W), word counter +1. If counter reaches load_len go to DONE, otherwise go to RECV.
  - DONE: core_hold=0, done=1, in_ready=0. A new start re-enters the load exactly as from IDLE, and done and core_hold return to 0 and 1 in the same cycle.
- Latency: wr_en is asserted the cycle after the 4th byte handshake. Minimum 5 cycles per word.
- start while in RECV or WRITE is ignored.
- in_valid with in_ready=0 does not transfer; the byte stays with the source.
- Bytes with in_valid=0 cause no index advance; stalls of any length are legal.
- Asynchronous reset mid-load discards the partial word. Words already written remain in memory, and core_hold returns high.
- load_len=2^LEN_W-1 must complete without counter overflow; the counter is LEN_W bits and compared for equality.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN
- With the macro defined:
  - Adds outputs chk_sum[31:0] and chk_err[0:0].
  - chk_sum = sum mod 2^32 of all words written in this load, cleared on start.
  - After the last data word, the loader takes one extra 4-byte word (state CHECK) that is never written to memory.
  - chk_err=1 in DONE if that word differs from chk_sum; chk_err is cleared on start and on reset.
  - The load_len=0 case also reads a checksum word; the expected value is 0.
- Without the macro: no extra ports, no CHECK state, no trailing word.

Decomposition:
- Shared package (imem_pkg):
  - FSM state encoding (IDLE, RECV, WRITE, CHECK, DONE)
  - WORD_BYTES=4
  - default BASE_ADDR constant, shared with IF reset PC
- Sub-module byte_packer (4-byte little-endian assembler with byte index and word_valid pulse) is natural. The FSM, address counter and word counter stay in imem_loader.

Test Plan:
- Reset then idle: after rst_n rises, core_hold=1, done=0, in_ready=0, no wr_en.
- Basic load: start with load_len=2; bytes 78,56,34,12,EF,BE,AD,DE, in_valid always high. Expect wr_en at addr 0 with 12345678, then at addr 4 with DEADBEEF. Then done=1 and core_hold=0.
- Stalled source: same stream as the basic load with in_valid toggling 1/0 every cycle. Expect identical writes, no duplicated or skipped bytes, and in_ready=0 during WRITE.
- Zero length / ignored start: start with load_len=0 gives done=1 the next cycle with no wr_en. A second start pulse while in RECV leaves the counters unchanged.
- Reset mid-word: after 2 bytes, pulse rst_n low. Expect no wr_en and core_hold=1. A new load of 1 word (11,22,33,44) writes 44332211 at addr 0.
- With IMEM_LOADER_CHECKSUM_EN:
  - Words 00000001, 00000002 followed by trailing word 00000003: chk_sum=3, chk_err=0, no write at addr 8.
  - Trailing word 00000004: chk_err=1.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg: shared loader FSM encoding, word geometry and default image base address
package imem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        CHECK,
        DONE
    } state_t;

    localparam int WORD_BYTES = 4;

    // The IF stage resets its PC to the same address the loader starts writing at
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles four accepted bytes into a little-endian 32-bit word
module byte_packer
    import imem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        take,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  idx;
    logic [31:0] next_word;

    assign word_valid = take && (idx == 2'(WORD_BYTES - 1));

    // Merge the incoming byte into its lane selected by the byte index
    always_comb begin
        next_word = word;
        next_word[{idx, 3'b000} +: 8] = data;
    end

    // Byte index and partial word; a new load discards any partial word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx  <= '0;
            word <= '0;
        end else if (clr) begin
            idx  <= '0;
            word <= '0;
        end else if (take) begin
            idx  <= idx + 2'd1;
            word <= next_word;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: byte-stream to instruction-memory writer holding the core until the image is loaded
// Optional trailing checksum word: define IMEM_LOADER_CHECKSUM_EN
module imem_loader
    import imem_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEFAULT_BASE_ADDR),
    parameter int                LEN_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  load_len,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              core_hold,
    output logic              done
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]       chk_sum,
    output logic [0:0]        chk_err
`endif
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t FIN = CHECK;
`else
    localparam state_t FIN = DONE;
`endif

    state_t           state, state_nxt;
    logic [LEN_W-1:0] len, cnt, cnt_nxt;
    logic             take, load, word_valid;
    logic [31:0]      word;

    assign take    = in_valid && in_ready;
    assign load    = start && (state == IDLE || state == DONE);
    assign cnt_nxt = cnt + LEN_W'(1);
    assign wr_data = word;

    byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (load),
        .take       (take),
        .data       (in_data),
        .word       (word),
        .word_valid (word_valid)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and Moore outputs; start is honoured only from IDLE or DONE
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        wr_en     = 1'b0;
        core_hold = 1'b1;
        done      = 1'b0;
        case (state)
            RECV: begin
                in_ready = 1'b1;
                if (word_valid) state_nxt = WRITE;
            end
            WRITE: begin
                wr_en     = 1'b1;
                state_nxt = (cnt_nxt == len) ? FIN : RECV;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                in_ready = 1'b1;
                if (word_valid) state_nxt = DONE;
            end
`endif
            DONE: begin
                core_hold = 1'b0;
                done      = 1'b1;
            end
            default: ;
        endcase
        if (load) state_nxt = (load_len == '0) ? FIN : RECV;
    end

    // Word address and word counter; equality compare keeps the max length free of overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr <= BASE_ADDR;
            len     <= '0;
            cnt     <= '0;
        end else if (load) begin
            wr_addr <= BASE_ADDR;
            len     <= load_len;
            cnt     <= '0;
        end else if (state == WRITE) begin
            wr_addr <= wr_addr + ADDR_W'(WORD_BYTES);
            cnt     <= cnt_nxt;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running sum of written words, compared against the trailing word as its last byte arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_sum <= '0;
            chk_err <= '0;
        end else if (load) begin
            chk_sum <= '0;
            chk_err <= '0;
        end else if (state == WRITE) begin
            chk_sum <= chk_sum + word;
        end else if (state == CHECK && word_valid) begin
            chk_err <= 1'({in_data, word[23:0]} != chk_sum);
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized loads checked against a byte-queue model of the image
module tb_imem_loader;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] load_len = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready, wr_en, core_hold, done;
    logic [31:0] wr_addr, wr_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] chk_sum;
    logic [0:0]  chk_err;
`endif

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_hs = -10;
    logic [31:0] got_a[$];
    logic [31:0] got_d[$];
    bq_t         basic, s, r;

    imem_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .load_len  (load_len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .core_hold (core_hold),
        .done      (done)
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        .chk_sum   (chk_sum),
        .chk_err   (chk_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Handshake history for the write-latency check
    always @(posedge clk) begin
        cyc++;
        if (in_valid && in_ready) last_hs = cyc;
    end

    // Capture every memory write; each must follow the 4th byte by one cycle with the stream blocked
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            got_a.push_back(wr_addr);
            got_d.push_back(wr_data);
            chk("wr_latency", 32'(cyc - last_hs), 32'd0);
            chk1("rdy_in_write", in_ready, 1'b0);
        end
    end

    // Image stream: n data words, plus the trailing sum word when the checksum build is used
    function automatic bq_t with_chk(input bq_t b, input int n);
        bq_t         q = b;
        logic [31:0] sum = '0;
        for (int i = 0; i < n; i++) sum += {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]};
`ifdef IMEM_LOADER_CHECKSUM_EN
        for (int k = 0; k < 4; k++) q.push_back(8'(sum >> (8 * k)));
`endif
        return q;
    endfunction

    task automatic do_start(input logic [15:0] n);
        @(negedge clk);
        start = 1'b1;
        load_len = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: always valid, 1: toggles every cycle, 2: random
    task automatic send(input bq_t b, input int mode);
        int   i = 0;
        int   budget = 4000;
        logic rdy;
        while (i < b.size() && budget > 0) begin
            @(negedge clk);
            in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(budget % 2) : 1'($urandom_range(0, 1));
            in_data = b[i];
            rdy = in_ready;
            @(posedge clk);
            if (in_valid && rdy) i++;
            budget--;
        end
        chk("send_complete", 32'(i), 32'(b.size()));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 500 && done !== 1'b1; k++) @(negedge clk);
        chk1({tag, "_done"}, done, 1'b1);
        chk1({tag, "_hold"}, core_hold, 1'b0);
        chk1({tag, "_rdy"}, in_ready, 1'b0);
    endtask

    // Expected writes: word i is bytes 4i..4i+3 little-endian at byte address 4i
    task automatic check_load(input string tag, input bq_t b, input int n);
        logic [31:0] w;
        chk({tag, "_nwr"}, 32'(got_a.size()), 32'(n));
        for (int i = 0; i < n && i < got_a.size(); i++) begin
            w = {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]};
            chk({tag, "_addr"}, got_a[i], 32'(4 * i));
            chk({tag, "_data"}, got_d[i], w);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk1({tag, "_chk_err"}, chk_err, 1'b0);
`endif
    endtask

    initial begin
        basic = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk1("rst_hold", core_hold, 1'b1);
        chk1("rst_done", done, 1'b0);
        chk1("rst_rdy", in_ready, 1'b0);
        chk1("rst_wr_en", wr_en, 1'b0);
        chk("rst_addr", wr_addr, 32'h0);
        chk("rst_data", wr_data, 32'h0);

        got_a.delete(); got_d.delete();
        do_start(16'd2);
        send(with_chk(basic, 2), 0);
        wait_done("basic");
        check_load("basic", basic, 2);
        if (got_d.size() == 2) begin
            chk("basic_w0", got_d[0], 32'h1234_5678);
            chk("basic_w1", got_d[1], 32'hDEAD_BEEF);
            chk("basic_a1", got_a[1], 32'h4);
        end

        got_a.delete(); got_d.delete();
        do_start(16'd2);
        chk1("restart_done", done, 1'b0);
        chk1("restart_hold", core_hold, 1'b1);
        send(with_chk(basic, 2), 1);
        wait_done("stall");
        check_load("stall", basic, 2);

        got_a.delete(); got_d.delete();
        do_start(16'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send('{8'h00, 8'h00, 8'h00, 8'h00}, 0);
        wait_done("zero");
        chk1("zero_chk_err", chk_err, 1'b0);
`else
        chk1("zero_done", done, 1'b1);
        repeat (3) @(negedge clk);
`endif
        chk("zero_nwr", 32'(got_a.size()), 32'd0);

        got_a.delete(); got_d.delete();
        do_start(16'd2);
        s = with_chk(basic, 2);
        send(s[0:1], 0);
        do_start(16'd5);
        send(s[2:$], 0);
        wait_done("ignstart");
        check_load("ignstart", basic, 2);

        got_a.delete(); got_d.delete();
        do_start(16'd3);
        send('{8'hA1, 8'hB2}, 0);
        rst_n = 1'b0;
        #2;
        chk1("midrst_hold", core_hold, 1'b1);
        chk1("midrst_rdy", in_ready, 1'b0);
        chk1("midrst_done", done, 1'b0);
        chk1("midrst_wr_en", wr_en, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_nwr", 32'(got_a.size()), 32'd0);
        do_start(16'd1);
        s = '{8'h11, 8'h22, 8'h33, 8'h44};
        send(with_chk(s, 1), 0);
        wait_done("midrst");
        check_load("midrst", s, 1);
        if (got_d.size() == 1) chk("midrst_w0", got_d[0], 32'h4433_2211);

        for (int it = 0; it < 5; it++) begin
            int n;
            n = $urandom_range(1, 4);
            r.delete();
            for (int k = 0; k < 4 * n; k++) r.push_back(8'($urandom));
            got_a.delete(); got_d.delete();
            do_start(16'(n));
            send(with_chk(r, n), 2);
            wait_done("rand");
            check_load("rand", r, n);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        got_a.delete(); got_d.delete();
        do_start(16'd2);
        send('{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00}, 0);
        wait_done("cks_ok");
        chk("cks_ok_nwr", 32'(got_a.size()), 32'd2);
        chk("cks_ok_sum", chk_sum, 32'd3);
        chk1("cks_ok_err", chk_err, 1'b0);
        do_start(16'd2);
        send('{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00}, 1);
        wait_done("cks_bad");
        chk1("cks_bad_err", chk_err, 1'b1);
        chk("cks_bad_nwr", 32'(got_a.size()), 32'd4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
